// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-channel, W-bit multiplexer with a registered output.
//
// Two operating modes:
//   direct - the external select picks the channel; dout/ch follow one clock
//            after sel/din.
//   scan   - an internal pointer walks through the channels, holding each one
//            for DWELL clocks; dout is sampled only at each switch
//            (sample-and-hold), so din changes between switches never reach
//            dout.
//
// Optional feature, enabled by defining MUX_SCAN_MASK_EN:
//   Adds an input ch_mask[N-1:0]. A channel with its mask bit clear is skipped
//   by the scan and reads as invalid in direct mode. With the macro undefined
//   every channel is enabled and there is no ch_mask port.
//
// The three-state FSM (IDLE / DIRECT / SCAN) is split into a state register,
// a next-state decoder and an output/datapath decoder.
module mux_nx1_scan #(
  parameter  int N     = 8,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] ch,
  output logic            valid
`ifdef MUX_SCAN_MASK_EN
  ,
  input  logic [N-1:0]    ch_mask
`endif
);

  // The dwell counter only has to reach DWELL-1; one extra bit keeps the
  // DWELL=1 case from collapsing to a zero-width vector.
  localparam int CNTW = $clog2(DWELL) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  // Output qualifier: valid is a single-cycle flag, with no ready/back-pressure.
  // It is high in exactly the cycles where dout/ch carry a freshly captured
  // sample; a consumer must take the sample in that cycle, because the block
  // never stalls and the next sample overwrites it.

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]    dout_q,  dout_d;
  logic [SELW-1:0] ch_q,    ch_d;
  logic            valid_q, valid_d;

  // Per-channel enables: the external mask when the feature is built in,
  // otherwise every channel is live.
  logic [N-1:0]    mask_w;
`ifdef MUX_SCAN_MASK_EN
  assign mask_w = ch_mask;
`else
  assign mask_w = {N{1'b1}};
`endif

  // Select the W-bit slice of channel idx; out-of-range indices read zero.
  function automatic logic [W-1:0] pick_chan(input logic [N*W-1:0] d,
                                             input int             idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == i) r = d[i*W +: W];
    end
    return r;
  endfunction

  // First enabled channel at or after 'start', wrapping modulo N.
  // Result is {found, index}; the downward loop lets the closest hit win.
  function automatic logic [SELW:0] find_enabled(input logic [N-1:0] m,
                                                 input int           start);
    logic [SELW:0] r;
    int            j;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (start + k) % N;
      if (m[j]) r = {1'b1, SELW'(j)};
    end
    return r;
  endfunction

  // Channel search results and direct-select qualification.
  logic [SELW:0] first_hit;   // lowest enabled channel (scan entry)
  logic [SELW:0] next_hit;    // next enabled channel after ch_q (scan switch)
  logic          sel_ok;      // sel is in range and its channel is enabled
  logic          mask_any;    // at least one channel enabled

  // Decode the channel searches and direct-select legality.
  always_comb begin
    first_hit = find_enabled(mask_w, 0);
    next_hit  = find_enabled(mask_w, int'(ch_q) + 1);
    mask_any  = |mask_w;
    sel_ok    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i) sel_ok = mask_w[i];
    end
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  // Next state depends only on en/mode, re-evaluated every clock.
  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      state_d = mode ? ST_SCAN : ST_DIRECT;
    end
  end

  // Datapath for the state being entered at this edge. Entering SCAN from any
  // other state restarts the sweep at the first enabled channel.
  always_comb begin
    dout_d  = dout_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    cnt_d   = '0;
    case (state_d)
      ST_IDLE: begin
        // Outputs frozen, counter cleared.
      end
      ST_DIRECT: begin
        ch_d = sel;
        if (sel_ok) begin
          dout_d  = pick_chan(din, int'(sel));
          valid_d = 1'b1;
        end else begin
          dout_d  = '0;
        end
      end
      ST_SCAN: begin
        if (state_q != ST_SCAN) begin
          // Scan entry: lowest enabled channel, fresh dwell.
          if (first_hit[SELW]) begin
            ch_d    = first_hit[SELW-1:0];
            dout_d  = pick_chan(din, int'(first_hit[SELW-1:0]));
            valid_d = 1'b1;
          end
        end else if (!mask_any) begin
          // Nothing to scan: hold outputs, keep the counter parked at 0.
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Dwell expired: capture the next enabled channel.
          if (next_hit[SELW]) begin
            ch_d    = next_hit[SELW-1:0];
            dout_d  = pick_chan(din, int'(next_hit[SELW-1:0]));
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        // Unreachable encoding: behave like IDLE.
      end
    endcase
  end

  assign dout  = dout_q;
  assign ch    = ch_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed testbench for mux_nx1_scan.
// dut   : N=8, W=8, DWELL=4  (reset, direct, scan sweep, disable, mode change, mask)
// dut6  : N=6, W=8, DWELL=4  (out-of-range select)
// dut5  : N=5, W=8, DWELL=1  (continuous scan with wrap 4->0)
module tb_mux_nx1_scan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [63:0] din;
  logic [2:0]  sel;
  logic        mode, en;
  logic [7:0]  dout;
  logic [2:0]  ch;
  logic        valid;

  logic [47:0] din6;
  logic [2:0]  sel6;
  logic        mode6, en6;
  logic [7:0]  dout6;
  logic [2:0]  ch6;
  logic        valid6;

  logic [39:0] din5;
  logic [2:0]  sel5;
  logic        mode5, en5;
  logic [7:0]  dout5;
  logic [2:0]  ch5;
  logic        valid5;

`ifdef MUX_SCAN_MASK_EN
  logic [7:0]  ch_mask;
  logic [5:0]  ch_mask6;
  logic [4:0]  ch_mask5;
`endif

  mux_nx1_scan #(.N(8), .W(8), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en(en),
    .dout(dout), .ch(ch), .valid(valid)
`ifdef MUX_SCAN_MASK_EN
    , .ch_mask(ch_mask)
`endif
  );

  mux_nx1_scan #(.N(6), .W(8), .DWELL(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .sel(sel6), .mode(mode6), .en(en6),
    .dout(dout6), .ch(ch6), .valid(valid6)
`ifdef MUX_SCAN_MASK_EN
    , .ch_mask(ch_mask6)
`endif
  );

  mux_nx1_scan #(.N(5), .W(8), .DWELL(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .din(din5), .sel(sel5), .mode(mode5), .en(en5),
    .dout(dout5), .ch(ch5), .valid(valid5)
`ifdef MUX_SCAN_MASK_EN
    , .ch_mask(ch_mask5)
`endif
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input int e_dout, input int e_ch, input int e_valid);
    check({tag, "_dout"},  32'(dout),  32'(e_dout));
    check({tag, "_ch"},    32'(ch),    32'(e_ch));
    check({tag, "_valid"}, 32'(valid), 32'(e_valid));
  endtask

  task automatic check_d6(input string tag, input int e_dout, input int e_ch, input int e_valid);
    check({tag, "_dout"},  32'(dout6),  32'(e_dout));
    check({tag, "_ch"},    32'(ch6),    32'(e_ch));
    check({tag, "_valid"}, 32'(valid6), 32'(e_valid));
  endtask

  task automatic check_d5(input string tag, input int e_dout, input int e_ch, input int e_valid);
    check({tag, "_dout"},  32'(dout5),  32'(e_dout));
    check({tag, "_ch"},    32'(ch5),    32'(e_ch));
    check({tag, "_valid"}, 32'(valid5), 32'(e_valid));
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    en = 1'b0; mode = 1'b0; sel = '0;
    en6 = 1'b0; mode6 = 1'b0; sel6 = '0;
    en5 = 1'b0; mode5 = 1'b0; sel5 = '0;
    for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'(16 + i);   // 8'h10+i
    for (int i = 0; i < 6; i++) din6[i*8 +: 8] = 8'(32 + i);  // 8'h20+i
    for (int i = 0; i < 5; i++) din5[i*8 +: 8] = 8'(48 + i);  // 8'h30+i
`ifdef MUX_SCAN_MASK_EN
    ch_mask = 8'hFF; ch_mask6 = 6'h3F; ch_mask5 = 5'h1F;
`endif

    // Reset state
    #1;
    check_main("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct select
    en = 1'b1; mode = 1'b0; sel = 3'd3;
    step(1);
    check_main("direct_sel3", 'h13, 3, 1);
    sel = 3'd7;
    step(1);
    check_main("direct_sel7", 'h17, 7, 1);

    // Scan sweep: entry then 8 switches (wrap 7->0), din change mid-dwell at ch 3
    mode = 1'b1;
    step(1);
    check_main("scan_entry", 'h10, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (k == 4 && j == 0) din[3*8 +: 8] = 8'hAA;
        step(1);
        check("scan_hold_valid", 32'(valid), 0);
        check("scan_hold_dout", 32'(dout), 32'('h10 + k - 1));
      end
      if (k == 4) din[3*8 +: 8] = 8'h13;
      step(1);
      check_main("scan_switch", 'h10 + (k % 8), k % 8, 1);
    end

    // Disable at ch 2: frozen outputs, then restart at ch 0
    step(8);
    check_main("scan_ch2", 'h12, 2, 1);
    en = 1'b0;
    step(1);
    check_main("idle_freeze", 'h12, 2, 0);
    din[2*8 +: 8] = 8'h5A;
    step(3);
    check_main("idle_hold", 'h12, 2, 0);
    din[2*8 +: 8] = 8'h12;
    en = 1'b1;
    step(1);
    check_main("reenable_restart", 'h10, 0, 1);

    // Asynchronous reset mid-scan at ch 5
    step(20);
    check_main("scan_ch5", 'h15, 5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_main("async_reset_mid", 0, 0, 0);
    rst_n = 1'b1;
    step(1);
    check_main("after_reset_entry", 'h10, 0, 1);

    // Mode change mid-dwell, then return to scan at ch 0
    step(2);
    mode = 1'b0; sel = 3'd4;
    step(1);
    check_main("mode_to_direct", 'h14, 4, 1);
    mode = 1'b1;
    step(1);
    check_main("mode_back_scan", 'h10, 0, 1);

    // N=6 direct, including out-of-range selects
    en6 = 1'b1; mode6 = 1'b0; sel6 = 3'd2;
    step(1);
    check_d6("n6_sel2", 'h22, 2, 1);
    sel6 = 3'd7;
    step(1);
    check_d6("n6_sel7_oor", 0, 7, 0);
    sel6 = 3'd6;
    step(1);
    check_d6("n6_sel6_oor", 0, 6, 0);
    sel6 = 3'd5;
    step(1);
    check_d6("n6_sel5", 'h25, 5, 1);

    // N=5, DWELL=1: advance every cycle, valid continuous, wrap 4->0
    en5 = 1'b1; mode5 = 1'b1;
    step(1);
    check_d5("d1_entry", 'h30, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check_d5("d1_step", 'h30 + (k % 5), k % 5, 1);
    end

`ifdef MUX_SCAN_MASK_EN
    // Masked scan: channels 2,5,7 enabled
    ch_mask = 8'b1010_0100;
    mode = 1'b0; sel = 3'd0;
    step(1);
    mode = 1'b1;
    step(1);
    check_main("mask_entry", 'h12, 2, 1);
    step(2);
    check("mask_mid_valid", 32'(valid), 0);
    step(2);
    check_main("mask_sw5", 'h15, 5, 1);
    step(4);
    check_main("mask_sw7", 'h17, 7, 1);
    step(4);
    check_main("mask_wrap2", 'h12, 2, 1);
    mode = 1'b0; sel = 3'd3;
    step(1);
    check_main("mask_direct_blocked", 0, 3, 0);
    ch_mask = 8'h00; mode = 1'b1;
    step(1);
    check_main("mask_zero_entry", 0, 3, 0);
    step(5);
    check_main("mask_zero_hold", 0, 3, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised successor to the gate-level 8:1 mux: N channels of W bits each, with a registered output.
- Two modes:
  - Direct: external select, 1-cycle latency.
  - Auto-scan: an internal counter steps through the channels, holding each for DWELL cycles. Each new sample is flagged with a valid pulse.
- Sits between multi-source data (sensor/ADC-style inputs) and a single-lane consumer.

Parameters:
- N, 8, number of input channels (>=2; need not be a power of 2).
- W, 8, bit width of each channel.
- DWELL, 4, clock cycles each channel is held in scan mode (>=1).
- SELW, $clog2(N), select/channel-index width. Derived localparam, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  N*W  packed channel inputs; channel i occupies din[i*W +: W].
- sel  input  SELW  channel select, used in direct mode only.
- mode  input  1  0 = direct, 1 = scan.
- en  input  1  block enable.
- dout  output  W  registered selected data.
- ch  output  SELW  index of the channel currently presented on dout.
- valid  output  1  dout/ch hold a new sample this cycle.

Behaviour:
- Reset (asynchronous, rst_n low):
  - dout=0, ch=0, valid=0, dwell counter=0, FSM=IDLE.
  - Takes effect immediately, even mid-scan.
  - Release is synchronous to clk.
- FSM states IDLE, DIRECT, SCAN. Next state evaluated each clock edge:
  - en=0 -> IDLE.
  - en=1 & mode=0 -> DIRECT.
  - en=1 & mode=1 -> SCAN.
- IDLE:
  - dout and ch hold their last values; valid=0.
  - Dwell counter cleared.
- DIRECT:
  - Every cycle: dout<=din[sel], ch<=sel, valid<=1. Latency 1 clock from sel/din to dout.
  - sel>=N (out of range): dout<=0, ch<=sel, valid<=0.
- SCAN entry (from IDLE or DIRECT):
  - Entry cycle: ch<=0, dout<=din[0], valid<=1, counter<=0.
- SCAN steady state:
  - Counter increments each cycle.
  - When counter==DWELL-1: ch<=next, dout<=din[next], valid<=1, counter<=0.
  - next = ch+1, wrapping from N-1 to 0.
  - All other cycles: valid=0, dout held (sample-and-hold). din changes between switches are not visible on dout.
- DWELL=1: channel advances every cycle and valid stays high continuously.
- Mode change mid-scan: takes effect at the next edge. Returning to scan always restarts at channel 0.
- en deassert mid-scan: go to IDLE, freeze outputs; resumes from channel 0.
- Counter width: $clog2(DWELL)+1 bits; it never exceeds DWELL-1.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds port ch_mask input N (bit i=1 means channel i enabled).
  - SCAN entry selects the lowest enabled channel instead of 0.
  - Each switch selects the next enabled channel in increasing order, with wrap.
  - If ch_mask is all zero in SCAN: ch and dout held, valid=0, counter held at 0.
  - DIRECT with sel pointing at a masked channel: dout<=0, valid<=0.
  - Mask changes take effect at the next switch decision.
- Undefined: no ch_mask port; all channels enabled; behaviour exactly as above.

Test Plan:
- Reset mid-scan: assert rst_n=0 at ch=5 -> dout=0, ch=0, valid=0 within the same cycle, without waiting for a clock edge.
- Direct select: N=8, W=8, din channel i = 8'h10+i, mode=0, en=1, sel=3 -> next edge dout=8'h13, ch=3, valid=1. Change sel to 7 -> dout=8'h17 one cycle later.
- Scan sweep and wrap: mode=1, DWELL=4 -> ch sequence 0,1,...,7,0 with a new value every 4 cycles, valid pulsed once per switch, dout=8'h10+ch. Changing din[ch] between switches leaves dout unchanged.
- Disable and out-of-range: en dropped at ch=2 -> outputs frozen, valid=0; re-enable -> restarts at ch=0. Separately, N=6, mode=0, sel=7 -> dout=0, valid=0.
- DWELL=1 run: ch increments every cycle with valid held high; N=5 wraps 4->0.
- Mask enabled (MUX_SCAN_MASK_EN): ch_mask=8'b1010_0100 -> ch sequence 2,5,7,2. ch_mask=0 -> outputs held, valid=0.
